// File: rtl/sram_bus_pkg.sv
// Shared types and default parameter values for the asynchronous SRAM bus controller.
package sram_bus_pkg;

    localparam int unsigned DEF_DATA_W   = 16;
    localparam int unsigned DEF_ADDR_W   = 20;
    localparam int unsigned DEF_WAIT_CYC = 2;
    localparam int unsigned DEF_TURN_CYC = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_TURN,
        S_ACCESS,
        S_DONE
    } state_e;

endpackage

// File: rtl/sram_wait_counter.sv
// Loadable down-counter that stops at zero and flags it; paces TURN and ACCESS phases.
module sram_wait_counter #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic [CNT_W-1:0] count_o,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;
    assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/sram_bus_ctrl.sv
// Single-transaction controller for an asynchronous SRAM with active-low controls,
// optional read-to-write bus turnaround and registered, glitch-free outputs.
module sram_bus_ctrl
    import sram_bus_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned WAIT_CYC = DEF_WAIT_CYC,
    parameter int unsigned TURN_CYC = DEF_TURN_CYC
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Req,
    input  logic                RW,
    input  logic [ADDR_W-1:0]   Addr,
    input  logic [DATA_W-1:0]   WrData,
    input  logic [DATA_W/8-1:0] ByteEn,
    output logic                Busy,
    output logic                Ready,
    output logic [DATA_W-1:0]   RdData,
    output logic                CE,
    output logic                OE,
    output logic                WE,
    output logic [DATA_W/8-1:0] BE_N,
    output logic [ADDR_W-1:0]   ADDR,
    inout  wire  [DATA_W-1:0]   Data
);

    localparam int unsigned LANES = DATA_W / 8;
    localparam int unsigned CNT_W = $clog2(WAIT_CYC + TURN_CYC + 1);
    localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] TURN_LD = (TURN_CYC > 0) ? CNT_W'(TURN_CYC - 1) : '0;

    state_e             state_q, state_d;
    logic               rw_q, last_rd_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q, rdata_q, rdata_d;
    logic [LANES-1:0]   be_q, be_n, ben_q, ben_d;
    logic               busy_q, ready_q, ce_q, oe_q, we_q, drive_q;
    logic               ce_d, oe_d, we_d, drive_d;
    logic               accept, wr_n, last_n;
    logic               cnt_load, cnt_zero;
    logic [CNT_W-1:0]   cnt_val, cnt_cur;

    sram_wait_counter #(.CNT_W(CNT_W)) u_wait (
        .clk_i      (Clk),
        .rst_i      (Reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .count_o    (cnt_cur),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        cnt_load = 1'b0;
        cnt_val  = '0;
        case (state_q)
            S_IDLE: begin
                if (Req) begin
                    accept   = 1'b1;
                    cnt_load = 1'b1;
                    if (last_rd_q && RW && (TURN_CYC > 0)) begin
                        state_d = S_TURN;
                        cnt_val = TURN_LD;
                    end else begin
                        state_d = S_ACCESS;
                        cnt_val = WAIT_LD;
                    end
                end
            end
            S_TURN: begin
                if (cnt_zero) begin
                    state_d  = S_ACCESS;
                    cnt_load = 1'b1;
                    cnt_val  = WAIT_LD;
                end
            end
            S_ACCESS: begin
                if (cnt_zero) begin
                    state_d  = S_DONE;
                    cnt_load = 1'b1;
                end
            end
            S_DONE: begin
                state_d  = S_IDLE;
                cnt_load = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state, so last_n predicts whether the
    // upcoming cycle is the final access cycle (WE must rise there for writes).
    always_comb begin
        wr_n    = accept ? RW : rw_q;
        be_n    = accept ? ByteEn : be_q;
        last_n  = (state_q == S_ACCESS) ? (cnt_cur == CNT_W'(1)) : (WAIT_CYC == 1);
        ce_d    = 1'b1;
        oe_d    = 1'b1;
        we_d    = 1'b1;
        ben_d   = '1;
        drive_d = 1'b0;
        if (state_d == S_ACCESS) begin
            ce_d    = 1'b0;
            oe_d    = wr_n;
            we_d    = !wr_n || (last_n && (WAIT_CYC > 1));
            ben_d   = ~be_n;
            drive_d = wr_n;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if ((state_q == S_ACCESS) && cnt_zero && !rw_q) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                rdata_d[l*8 +: 8] = be_q[l] ? Data[l*8 +: 8] : 8'h00;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            rw_q      <= 1'b0;
            last_rd_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            rdata_q   <= '0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
            ce_q      <= 1'b1;
            oe_q      <= 1'b1;
            we_q      <= 1'b1;
            ben_q     <= '1;
            drive_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rw_q    <= RW;
                addr_q  <= Addr;
                wdata_q <= WrData;
                be_q    <= ByteEn;
            end
            if ((state_q == S_ACCESS) && (state_d == S_DONE)) begin
                last_rd_q <= !rw_q;
            end
            rdata_q <= rdata_d;
            busy_q  <= (state_d != S_IDLE);
            ready_q <= (state_d == S_DONE);
            ce_q    <= ce_d;
            oe_q    <= oe_d;
            we_q    <= we_d;
            ben_q   <= ben_d;
            drive_q <= drive_d;
        end
    end

    assign Busy   = busy_q;
    assign Ready  = ready_q;
    assign RdData = rdata_q;
    assign CE     = ce_q;
    assign OE     = oe_q;
    assign WE     = we_q;
    assign BE_N   = ben_q;
    assign ADDR   = addr_q;
    assign Data   = drive_q ? wdata_q : 'z;

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Scoreboard bench: stimulus pushes expected per-cycle bus state and completions,
// a negedge monitor pops and compares against two controller configurations.
module tb_sram_bus_ctrl;

    typedef struct {
        int          cyc;
        logic [8:0]  ctl;   // {CE,OE,WE,BE_N[3:0],Busy,Ready}
        logic        ca;
        logic [19:0] addr;
        logic        cd;
        logic [31:0] data;
        logic        cr;
        logic [31:0] rd;
    } ctl_t;

    typedef struct {
        int          cyc;
        logic [31:0] rd;
    } rsp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    bit stim_done = 1'b0;

    ctl_t ctl_a[$], ctl_b[$];
    rsp_t rsp_a[$], rsp_b[$];

    // instance A: defaults (16-bit, WAIT 2, TURN 1)
    logic        Reset_a = 1'b1, Req_a = 1'b0, RW_a = 1'b0;
    logic [19:0] Addr_a = '0;
    logic [15:0] WrData_a = '0;
    logic [1:0]  ByteEn_a = '0;
    logic        Busy_a, Ready_a, CE_a, OE_a, WE_a;
    logic [15:0] RdData_a;
    logic [1:0]  BE_N_a;
    logic [19:0] ADDR_a;
    wire  [15:0] Data_a;

    // instance B: 32-bit, WAIT 1, TURN 1
    logic        Reset_b = 1'b1, Req_b = 1'b0, RW_b = 1'b0;
    logic [19:0] Addr_b = '0;
    logic [31:0] WrData_b = '0;
    logic [3:0]  ByteEn_b = '0;
    logic        Busy_b, Ready_b, CE_b, OE_b, WE_b;
    logic [31:0] RdData_b;
    logic [3:0]  BE_N_b;
    logic [19:0] ADDR_b;
    wire  [31:0] Data_b;

    sram_bus_ctrl #(.DATA_W(16), .ADDR_W(20), .WAIT_CYC(2), .TURN_CYC(1)) u_dut_a (
        .Clk(clk), .Reset(Reset_a), .Req(Req_a), .RW(RW_a), .Addr(Addr_a),
        .WrData(WrData_a), .ByteEn(ByteEn_a), .Busy(Busy_a), .Ready(Ready_a),
        .RdData(RdData_a), .CE(CE_a), .OE(OE_a), .WE(WE_a), .BE_N(BE_N_a),
        .ADDR(ADDR_a), .Data(Data_a)
    );

    sram_bus_ctrl #(.DATA_W(32), .ADDR_W(20), .WAIT_CYC(1), .TURN_CYC(1)) u_dut_b (
        .Clk(clk), .Reset(Reset_b), .Req(Req_b), .RW(RW_b), .Addr(Addr_b),
        .WrData(WrData_b), .ByteEn(ByteEn_b), .Busy(Busy_b), .Ready(Ready_b),
        .RdData(RdData_b), .CE(CE_b), .OE(OE_b), .WE(WE_b), .BE_N(BE_N_b),
        .ADDR(ADDR_b), .Data(Data_b)
    );

    // SRAM models: drive while selected for read, store enabled lanes while WE is low
    logic [15:0] mem_a [256];
    logic [31:0] mem_b [256];
    assign Data_a = (!CE_a && !OE_a && WE_a) ? mem_a[ADDR_a[7:0]] : 16'hzzzz;
    assign Data_b = (!CE_b && !OE_b && WE_b) ? mem_b[ADDR_b[7:0]] : 32'hzzzz_zzzz;

    always @(posedge clk) begin
        if (cyc == 0) begin
            mem_a[8'h12] <= 16'hBEEF;
            mem_a[8'h34] <= 16'h5678;
            mem_a[8'h40] <= 16'h0000;
            mem_a[8'h50] <= 16'h0F0F;
            mem_a[8'h60] <= 16'h0000;
            mem_b[8'h05] <= 32'h11AA_22CC;
            mem_b[8'h06] <= 32'h0000_0000;
        end else begin
            if (!CE_a && !WE_a)
                for (int l = 0; l < 2; l++)
                    if (!BE_N_a[l]) mem_a[ADDR_a[7:0]][l*8 +: 8] <= Data_a[l*8 +: 8];
            if (!CE_b && !WE_b)
                for (int l = 0; l < 4; l++)
                    if (!BE_N_b[l]) mem_b[ADDR_b[7:0]][l*8 +: 8] <= Data_b[l*8 +: 8];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic ctl_t mk(input int c, input logic [8:0] v, input logic ca,
                                input logic [19:0] a, input logic cd, input logic [31:0] d,
                                input logic cr, input logic [31:0] r);
        ctl_t e;
        e.cyc = c; e.ctl = v; e.ca = ca; e.addr = a;
        e.cd = cd; e.data = d; e.cr = cr; e.rd = r;
        return e;
    endfunction

    task automatic push_ctl(input bit b, input ctl_t e);
        if (b) ctl_b.push_back(e); else ctl_a.push_back(e);
    endtask

    // Expected bus waveform for one transaction whose Req is high in cycle c.
    task automatic expect_txn(input bit b, input int c, input logic rw, input logic [19:0] a,
                              input logic [31:0] wd, input logic [3:0] be, input bit turn,
                              input int w, input bit abort, input logic [31:0] exp_rd);
        int t = c + 1;
        rsp_t r;
        if (turn) begin
            push_ctl(b, mk(t, {3'b111, 4'hF, 2'b10}, 1'b0, '0, 1'b0, '0, 1'b0, '0));
            t++;
        end
        for (int k = 0; k < w; k++) begin
            logic we;
            we = rw ? ((w > 1) && (k == w - 1)) : 1'b1;
            push_ctl(b, mk(t + k, {1'b0, rw, we, ~be, 2'b10}, 1'b1, a, rw, wd, 1'b0, '0));
        end
        if (!abort) begin
            push_ctl(b, mk(t + w, {3'b111, 4'hF, 2'b11}, 1'b0, '0, 1'b0, '0, 1'b0, '0));
            r.cyc = t + w;
            r.rd  = exp_rd;
            if (b) rsp_b.push_back(r); else rsp_a.push_back(r);
        end
    endtask

    task automatic issue(input bit b, input logic rw, input logic [19:0] a, input logic [31:0] wd,
                         input logic [3:0] be, input bit turn, input logic [31:0] exp_rd,
                         input bit hold, input bit abort);
        int w = b ? 1 : 2;
        expect_txn(b, cyc, rw, a, wd, be, turn, w, abort, exp_rd);
        if (b) begin
            Req_b = 1'b1; RW_b = rw; Addr_b = a; WrData_b = wd; ByteEn_b = be;
        end else begin
            Req_a = 1'b1; RW_a = rw; Addr_a = a; WrData_a = wd[15:0]; ByteEn_a = be[1:0];
        end
        @(posedge clk); #1;
        Req_a = 1'b0;
        Req_b = 1'b0;
        if (!hold) repeat (w + int'(turn) + 1) begin @(posedge clk); #1; end
    endtask

    task automatic check_ctl(input string tag, input ctl_t e, input logic [8:0] act_ctl,
                             input logic [19:0] act_addr, input logic [31:0] act_data,
                             input logic [31:0] act_rd);
        chk({tag, "_ctl"}, 64'(act_ctl), 64'(e.ctl));
        if (e.ca) chk({tag, "_addr"}, 64'(act_addr), 64'(e.addr));
        if (e.cd) chk({tag, "_wdata"}, 64'(act_data), 64'(e.data));
        if (e.cr) chk({tag, "_rddata_reset"}, 64'(act_rd), 64'(e.rd));
    endtask

    always @(negedge clk) begin
        rsp_t r;
        bit   exp_rdy;
        if (ctl_a.size() > 0 && ctl_a[0].cyc == cyc)
            check_ctl("a", ctl_a.pop_front(), {CE_a, OE_a, WE_a, 2'b11, BE_N_a, Busy_a, Ready_a},
                      ADDR_a, 32'(Data_a), 32'(RdData_a));
        if (ctl_b.size() > 0 && ctl_b[0].cyc == cyc)
            check_ctl("b", ctl_b.pop_front(), {CE_b, OE_b, WE_b, BE_N_b, Busy_b, Ready_b},
                      ADDR_b, Data_b, RdData_b);

        exp_rdy = (rsp_a.size() > 0) && (rsp_a[0].cyc == cyc);
        if (Ready_a || exp_rdy) begin
            chk("a_ready", 64'(Ready_a), 64'(exp_rdy));
            if (exp_rdy) begin
                r = rsp_a.pop_front();
                chk("a_rddata", 64'(RdData_a), 64'(r.rd));
            end
        end
        exp_rdy = (rsp_b.size() > 0) && (rsp_b[0].cyc == cyc);
        if (Ready_b || exp_rdy) begin
            chk("b_ready", 64'(Ready_b), 64'(exp_rdy));
            if (exp_rdy) begin
                r = rsp_b.pop_front();
                chk("b_rddata", 64'(RdData_b), 64'(r.rd));
            end
        end

        if (stim_done || cyc > 3000) begin
            if (!stim_done) begin
                checks++;
                failures++;
                $display("FAIL timeout cyc=%0d got=running expected=done", cyc);
            end
            chk("a_pending_rsp", 64'(rsp_a.size()), 64'd0);
            chk("b_pending_rsp", 64'(rsp_b.size()), 64'd0);
            chk("a_pending_ctl", 64'(ctl_a.size()), 64'd0);
            chk("b_pending_ctl", 64'(ctl_b.size()), 64'd0);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    initial begin
        int c;
        repeat (3) @(posedge clk);
        #1;
        Reset_a = 1'b0;
        Reset_b = 1'b0;
        push_ctl(1'b0, mk(cyc, {3'b111, 4'hF, 2'b00}, 1'b1, '0, 1'b0, '0, 1'b1, '0));
        push_ctl(1'b1, mk(cyc, {3'b111, 4'hF, 2'b00}, 1'b1, '0, 1'b0, '0, 1'b1, '0));
        @(posedge clk); #1;

        // instance A directed vectors
        issue(0, 1'b1, 20'h00034, 32'h1234, 4'b0001, 0, 32'h0000, 0, 0);
        issue(0, 1'b0, 20'h00034, 32'h0,    4'b0011, 0, 32'h5634, 0, 0);
        issue(0, 1'b0, 20'h00012, 32'h0,    4'b0011, 0, 32'hBEEF, 0, 0);
        issue(0, 1'b1, 20'h00040, 32'hCAFE, 4'b0011, 1, 32'hBEEF, 0, 0);
        issue(0, 1'b0, 20'h00040, 32'h0,    4'b0011, 0, 32'hCAFE, 0, 0);

        // second Req while busy must be dropped without effect
        issue(0, 1'b0, 20'h00050, 32'h0,    4'b0011, 0, 32'h0F0F, 1, 0);
        Req_a = 1'b1; RW_a = 1'b1; Addr_a = 20'h00050; WrData_a = 16'hDEAD; ByteEn_a = 2'b11;
        @(posedge clk); #1;
        Req_a = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        issue(0, 1'b0, 20'h00050, 32'h0,    4'b0011, 0, 32'h0F0F, 0, 0);
        issue(0, 1'b0, 20'h00012, 32'h0,    4'b0000, 0, 32'h0000, 0, 0);

        // reset during the second access cycle of a write (after turnaround)
        c = cyc;
        issue(0, 1'b1, 20'h00060, 32'h7777, 4'b0011, 1, 32'h0000, 1, 1);
        repeat (2) begin @(posedge clk); #1; end
        Reset_a = 1'b1;
        @(posedge clk); #1;
        Reset_a = 1'b0;
        push_ctl(1'b0, mk(c + 4, {3'b111, 4'hF, 2'b00}, 1'b1, '0, 1'b0, '0, 1'b1, '0));
        @(posedge clk); #1;
        issue(0, 1'b1, 20'h00060, 32'h1111, 4'b0011, 0, 32'h0000, 0, 0);
        issue(0, 1'b0, 20'h00060, 32'h0,    4'b0011, 0, 32'h1111, 0, 0);

        // instance B: 32-bit, single access cycle
        issue(1, 1'b1, 20'h00006, 32'h0102_0304, 4'b1111, 0, 32'h0000_0000, 0, 0);
        issue(1, 1'b0, 20'h00006, 32'h0,         4'b1111, 0, 32'h0102_0304, 0, 0);
        issue(1, 1'b0, 20'h00005, 32'h0,         4'b0101, 0, 32'h00AA_00CC, 0, 0);

        repeat (3) begin @(posedge clk); #1; end
        stim_done = 1'b1;
    end

endmodule
